// File: rtl/aes_round_ctrl.sv
// -----------------------------------------------------------------------------
// aes_round_ctrl
//
// Sequencer for the iterative AES round datapath of the AES HWPE engine.
// Takes a job (key length, direction, block count) from the top-level FSM.
// It triggers key expansion and then, for every block:
//   - accepts a 128-bit input block (in_valid/in_ready),
//   - drives one load cycle followed by Nr round cycles,
//   - presents the result (out_valid/out_ready).
// It pulses done when the last block has been handed off.
//
// Handshake rule: a transfer happens on a rising clk edge where valid and
// ready are both high. A valid source holds valid and its payload stable
// until that edge. Ready may depend on the other side's valid or ready only
// where this header says so.
//
// Optional feature (macro AES_ROUND_CTRL_BACK2BACK_EN):
//   When defined, in_ready follows out_ready while a result is held and more
//   blocks remain. A simultaneous output and input transfer then loads the
//   next block straight into ROUND, for one block every Nr+1 cycles. When
//   undefined, in_ready is only high in READY, for one block every Nr+2
//   cycles at most.
//
// Ports:
//   clk, reset, clear      clock, sync active-high reset, sync soft clear
//   start                  job start pulse (IDLE only)
//   cfg_key_len            0=AES-128, 1=AES-192, 2=AES-256, 3=illegal
//   cfg_decrypt            1 = inverse cipher
//   cfg_num_blocks         blocks in the job
//   ks_start / ks_done     key-expansion trigger / key schedule ready
//   in_valid / in_ready    input block handshake
//   dp_load                datapath loads input XOR round key dp_round_idx
//   dp_round_en            datapath executes one round
//   dp_round_idx           round-key index for this cycle
//   dp_final_round         this round omits (Inv)MixColumns
//   dp_inv                 latched direction
//   out_valid / out_ready  result block handshake
//   busy, done, err_cfg    status; done and err_cfg are one-cycle pulses
//   block_cnt              blocks completed in the current job
//   dbg_state              current FSM state encoding (debug observation)
// -----------------------------------------------------------------------------
module aes_round_ctrl #(
  parameter int CNT_W  = 16,
  parameter int RIDX_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              start,
  input  logic [1:0]        cfg_key_len,
  input  logic              cfg_decrypt,
  input  logic [CNT_W-1:0]  cfg_num_blocks,
  output logic              ks_start,
  input  logic              ks_done,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              dp_load,
  output logic              dp_round_en,
  output logic [RIDX_W-1:0] dp_round_idx,
  output logic              dp_final_round,
  output logic              dp_inv,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic              err_cfg,
  output logic [CNT_W-1:0]  block_cnt,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_KEY_EXP = 3'd1,
    S_READY   = 3'd2,
    S_ROUND   = 3'd3,
    S_HOLD    = 3'd4
  } state_t;

  // Number of rounds for a key length; the illegal code never reaches here.
  function automatic logic [RIDX_W-1:0] nr_of(input logic [1:0] kl);
    case (kl)
      2'd0:    nr_of = RIDX_W'(10);
      2'd1:    nr_of = RIDX_W'(12);
      default: nr_of = RIDX_W'(14);
    endcase
  endfunction

  state_t             state_q, state_d;
  logic [RIDX_W-1:0]  nr_q, nr_d;
  logic               dec_q, dec_d;
  logic [CNT_W-1:0]   num_blocks_q, num_blocks_d;
  logic [CNT_W-1:0]   block_cnt_q, block_cnt_d;
  logic [RIDX_W-1:0]  round_idx_q, round_idx_d;
  logic               final_q, final_d;
  logic               round_en_q, round_en_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic               ks_start_q, ks_start_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_cfg_q, err_cfg_d;

  logic               last_blk;
  logic               in_hs;
  logic               out_hs;
  logic [RIDX_W-1:0]  load_idx;
  logic [RIDX_W-1:0]  first_idx;
  logic [RIDX_W-1:0]  final_idx;

  // The block being held is the last one of the job.
  assign last_blk  = (block_cnt_q + CNT_W'(1)) == num_blocks_q;

  // Round-key indices: encryption walks 0 (load), 1..Nr; decryption walks
  // Nr (load), Nr-1..0.
  assign load_idx  = dec_q ? nr_q : '0;
  assign first_idx = dec_q ? (nr_q - RIDX_W'(1)) : RIDX_W'(1);
  assign final_idx = dec_q ? '0 : nr_q;

`ifdef AES_ROUND_CTRL_BACK2BACK_EN
  // While a result is held and more blocks remain, accept the next block in
  // the same cycle the sink takes the result.
  assign in_ready = in_ready_q | ((state_q == S_HOLD) & ~last_blk & out_ready);
`else
  assign in_ready = in_ready_q;
`endif

  assign in_hs  = in_ready & in_valid;
  assign out_hs = out_valid_q & out_ready;

  // The load happens in the input-handshake cycle itself, so dp_load and its
  // index qualify the registered ready with the live in_valid.
  assign dp_load      = in_hs;
  assign dp_round_idx = round_en_q ? round_idx_q : (in_hs ? load_idx : '0);

  assign ks_start       = ks_start_q;
  assign dp_round_en    = round_en_q;
  assign dp_final_round = final_q;
  assign dp_inv         = dec_q;
  assign out_valid      = out_valid_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign err_cfg        = err_cfg_q;
  assign block_cnt      = block_cnt_q;
  assign dbg_state      = state_q;

  always_comb begin
    state_d      = state_q;
    nr_d         = nr_q;
    dec_d        = dec_q;
    num_blocks_d = num_blocks_q;
    block_cnt_d  = block_cnt_q;
    round_idx_d  = '0;
    ks_start_d   = 1'b0;
    done_d       = 1'b0;
    err_cfg_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (cfg_key_len == 2'd3) begin
            err_cfg_d = 1'b1;
          end else if (cfg_num_blocks == '0) begin
            done_d = 1'b1;
          end else begin
            state_d      = S_KEY_EXP;
            ks_start_d   = 1'b1;
            block_cnt_d  = '0;
            nr_d         = nr_of(cfg_key_len);
            dec_d        = cfg_decrypt;
            num_blocks_d = cfg_num_blocks;
          end
        end
      end

      S_KEY_EXP: begin
        // ks_done is ignored in the ks_start cycle so that a level left
        // high from an earlier job cannot skip the expansion.
        if (!ks_start_q && ks_done) begin
          state_d = S_READY;
        end
      end

      S_READY: begin
        if (in_hs) begin
          state_d     = S_ROUND;
          round_idx_d = first_idx;
        end
      end

      S_ROUND: begin
        if (final_q) begin
          state_d = S_HOLD;
        end else begin
          round_idx_d = dec_q ? (round_idx_q - RIDX_W'(1))
                              : (round_idx_q + RIDX_W'(1));
        end
      end

      S_HOLD: begin
        if (out_hs) begin
          block_cnt_d = block_cnt_q + CNT_W'(1);
          if (last_blk) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else if (in_hs) begin
            // Only reachable with back-to-back loading enabled.
            state_d     = S_ROUND;
            round_idx_d = first_idx;
          end else begin
            state_d = S_READY;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Level outputs are registered from the next state.
    in_ready_d  = (state_d == S_READY);
    out_valid_d = (state_d == S_HOLD);
    round_en_d  = (state_d == S_ROUND);
    busy_d      = (state_d != S_IDLE);
    final_d     = (state_d == S_ROUND) && (round_idx_d == final_idx);
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state_q      <= S_IDLE;
      nr_q         <= '0;
      dec_q        <= 1'b0;
      num_blocks_q <= '0;
      block_cnt_q  <= '0;
      round_idx_q  <= '0;
      final_q      <= 1'b0;
      round_en_q   <= 1'b0;
      in_ready_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      ks_start_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_cfg_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      nr_q         <= nr_d;
      dec_q        <= dec_d;
      num_blocks_q <= num_blocks_d;
      block_cnt_q  <= block_cnt_d;
      round_idx_q  <= round_idx_d;
      final_q      <= final_d;
      round_en_q   <= round_en_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      ks_start_q   <= ks_start_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_cfg_q    <= err_cfg_d;
    end
  end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// -----------------------------------------------------------------------------
// tb_aes_round_ctrl
//
// Self-checking bench for aes_round_ctrl. Inputs change on the falling clk
// edge and outputs are sampled 1 ns later, well away from the rising edge.
// Job vectors live in a table of hand-computed records. Hand-written
// sequences cover these cases:
//   - illegal key length and zero-block starts,
//   - clear racing start,
//   - reset in the middle of a job,
//   - steady-state throughput.
// -----------------------------------------------------------------------------
module tb_aes_round_ctrl;

  localparam int CNT_W  = 16;
  localparam int RIDX_W = 4;

`ifdef AES_ROUND_CTRL_BACK2BACK_EN
  localparam int PERIOD = 11;
`else
  localparam int PERIOD = 12;
`endif

  // ---------------- clock / reset ----------------
  logic              clk;
  logic              reset;
  logic              clear;
  logic              start;
  logic [1:0]        cfg_key_len;
  logic              cfg_decrypt;
  logic [CNT_W-1:0]  cfg_num_blocks;
  logic              ks_start;
  logic              ks_done;
  logic              in_valid;
  logic              in_ready;
  logic              dp_load;
  logic              dp_round_en;
  logic [RIDX_W-1:0] dp_round_idx;
  logic              dp_final_round;
  logic              dp_inv;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              done;
  logic              err_cfg;
  logic [CNT_W-1:0]  block_cnt;
  logic [2:0]        dbg_state;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  aes_round_ctrl #(.CNT_W(CNT_W), .RIDX_W(RIDX_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .clear          (clear),
    .start          (start),
    .cfg_key_len    (cfg_key_len),
    .cfg_decrypt    (cfg_decrypt),
    .cfg_num_blocks (cfg_num_blocks),
    .ks_start       (ks_start),
    .ks_done        (ks_done),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .dp_load        (dp_load),
    .dp_round_en    (dp_round_en),
    .dp_round_idx   (dp_round_idx),
    .dp_final_round (dp_final_round),
    .dp_inv         (dp_inv),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .busy           (busy),
    .done           (done),
    .err_cfg        (err_cfg),
    .block_cnt      (block_cnt),
    .dbg_state      (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [RIDX_W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- job table ----------------
  typedef struct {
    logic [1:0]       key_len;
    logic             dec;
    logic [CNT_W-1:0] nblk;
    int               ks_delay;   // cycle (after start) at which ks_done rises, >= 2
    int               hold_wait;  // cycles out_ready stays low once out_valid is up
    int               exp_nr;     // expected number of round cycles
    int               exp_load;   // expected round index in the load cycle
  } vec_t;

  localparam int NVEC = 6;
  vec_t tbl[NVEC];

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    start = 1'b0; clear = 1'b0; ks_done = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0;
  endtask

  // Runs one complete job from IDLE and checks every cycle of it.
  task automatic run_job(input int v);
    vec_t t;
    t = tbl[v];
    tick();
    cfg_key_len = t.key_len; cfg_decrypt = t.dec; cfg_num_blocks = t.nblk;
    start = 1'b1; in_valid = 1'b1; out_ready = 1'b0; ks_done = 1'b0;
    #1 chk("job_idle_busy", busy, 0);

    for (int i = 1; i <= t.ks_delay; i++) begin
      tick();
      start = 1'b0;
      if (i == 1) begin
        // Configuration must be latched at start; scramble it afterwards.
        cfg_key_len    = 2'($urandom_range(0, 3));
        cfg_decrypt    = ~t.dec;
        cfg_num_blocks = CNT_W'($urandom_range(0, 9));
      end
      ks_done = (i == t.ks_delay);
      #1;
      chk("ks_start", ks_start, (i == 1));
      chk("kexp_in_ready", in_ready, 0);
      chk("kexp_busy", busy, 1);
      if (i == 1) chk("dp_inv", dp_inv, t.dec);
    end

    for (int b = 0; b < int'(t.nblk); b++) begin
      // Expected index sequence for this block: load, then Nr rounds.
      exp_q.delete();
      exp_q.push_back(RIDX_W'(t.exp_load));
      for (int r = 1; r <= t.exp_nr; r++)
        exp_q.push_back(t.dec ? RIDX_W'(t.exp_load - r) : RIDX_W'(r));

`ifdef AES_ROUND_CTRL_BACK2BACK_EN
      if (b == 0) begin
`else
      begin
`endif
        tick();
        ks_done = 1'b0;
        #1;
        chk("load_in_ready", in_ready, 1);
        chk("load_dp_load", dp_load, 1);
        chk("load_idx", dp_round_idx, exp_q[0]);
        chk("load_round_en", dp_round_en, 0);
      end
      void'(exp_q.pop_front());

      for (int r = 1; r <= t.exp_nr; r++) begin
        tick();
        ks_done = 1'b0;
        start = (r == 1);   // start while busy must be ignored
        #1;
        chk("round_en", dp_round_en, 1);
        chk("round_idx", dp_round_idx, exp_q.pop_front());
        chk("round_final", dp_final_round, (r == t.exp_nr));
        chk("round_in_ready", in_ready, 0);
        chk("round_dp_load", dp_load, 0);
        if (r == 1) chk("round_block_cnt", block_cnt, b);
        if (r == t.exp_nr) chk("round_out_valid", out_valid, 0);
      end

      for (int w = 0; w < t.hold_wait; w++) begin
        tick();
        start = 1'b0; out_ready = 1'b0;
        #1;
        chk("hold_out_valid", out_valid, 1);
        chk("hold_in_ready", in_ready, 0);
        chk("hold_round_en", dp_round_en, 0);
      end

      tick();
      start = 1'b0; out_ready = 1'b1;
      #1;
      chk("hs_out_valid", out_valid, 1);
`ifdef AES_ROUND_CTRL_BACK2BACK_EN
      if (b < int'(t.nblk) - 1) begin
        chk("b2b_dp_load", dp_load, 1);
        chk("b2b_load_idx", dp_round_idx, RIDX_W'(t.exp_load));
      end
`endif
    end

    tick();
    out_ready = 1'b0; in_valid = 1'b0;
    #1;
    chk("end_done", done, 1);
    chk("end_busy", busy, 0);
    chk("end_block_cnt", block_cnt, t.nblk);
    chk("end_out_valid", out_valid, 0);
    tick();
    #1;
    chk("end_done_pulse", done, 0);
    chk("end_block_cnt_hold", block_cnt, t.nblk);
  endtask

  // ---------------- test sequence ----------------
  int found;
  int n_ov;
  int done_cyc;
  int ov_cyc[8];

  initial begin
    //           key dec nblk ksd hold nr  load
    tbl[0] = '{2'd0, 1'b0, 16'd1, 3, 0, 10, 0};
    tbl[1] = '{2'd2, 1'b1, 16'd2, 4, 5, 14, 14};
    tbl[2] = '{2'd1, 1'b0, 16'd1, 2, 1, 12, 0};
    tbl[3] = '{2'd1, 1'b1, 16'd1, 2, 0, 12, 12};
    tbl[4] = '{2'd0, 1'b1, 16'd2, 5, 2, 10, 10};
    tbl[5] = '{2'd2, 1'b0, 16'd1, 2, 0, 14, 0};

    idle_inputs();
    cfg_key_len = 2'd0; cfg_decrypt = 1'b0; cfg_num_blocks = '0;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    #1;
    chk("rst_outputs", {ks_start, in_ready, dp_load, dp_round_en, dp_round_idx,
                        dp_final_round, dp_inv, out_valid, busy, done, err_cfg}, 0);
    chk("rst_block_cnt", block_cnt, 0);
    chk("rst_state", dbg_state, 0);

    // Illegal key length
    tick();
    cfg_key_len = 2'd3; cfg_num_blocks = 16'd5; start = 1'b1;
    tick();
    start = 1'b0;
    #1;
    chk("err_pulse", err_cfg, 1);
    chk("err_busy", busy, 0);
    chk("err_ks_start", ks_start, 0);
    tick();
    #1;
    chk("err_pulse_end", err_cfg, 0);
    chk("err_busy2", busy, 0);

    // Zero-block job
    tick();
    cfg_key_len = 2'd0; cfg_num_blocks = 16'd0; start = 1'b1;
    tick();
    start = 1'b0;
    #1;
    chk("zero_done", done, 1);
    chk("zero_ks_start", ks_start, 0);
    chk("zero_in_ready", in_ready, 0);
    chk("zero_busy", busy, 0);
    tick();
    #1;
    chk("zero_done_end", done, 0);

    // clear wins over start
    tick();
    cfg_key_len = 2'd0; cfg_num_blocks = 16'd1; start = 1'b1; clear = 1'b1;
    tick();
    start = 1'b0; clear = 1'b0;
    #1;
    chk("clear_busy", busy, 0);
    chk("clear_ks_start", ks_start, 0);

    // Table-driven jobs
    for (int v = 0; v < NVEC; v++) run_job(v);

    // Reset during round 6 of block 2 of a 3-block AES-192 job
    tick();
    cfg_key_len = 2'd1; cfg_decrypt = 1'b0; cfg_num_blocks = 16'd3;
    start = 1'b1; in_valid = 1'b1; out_ready = 1'b1; ks_done = 1'b0;
    tick();
    start = 1'b0; ks_done = 1'b1;
    found = 0;
    for (int c = 0; c < 60; c++) begin
      tick();
      #1;
      if (dp_round_en && dp_round_idx == 4'd6 && block_cnt == 16'd1) begin
        found = 1;
        reset = 1'b1;
        break;
      end
    end
    chk("midrst_reached", found, 1);
    tick();
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; ks_done = 1'b0;
    #1;
    chk("midrst_outputs", {ks_start, in_ready, dp_load, dp_round_en, dp_round_idx,
                           dp_final_round, dp_inv, out_valid, busy, done, err_cfg}, 0);
    chk("midrst_block_cnt", block_cnt, 0);
    for (int c = 0; c < 4; c++) begin
      tick();
      #1;
      chk("midrst_no_done", {done, busy}, 0);
    end
    run_job(0);

    // Throughput: AES-128 enc, 4 blocks, everything always ready
    tick();
    cfg_key_len = 2'd0; cfg_decrypt = 1'b0; cfg_num_blocks = 16'd4;
    start = 1'b1; in_valid = 1'b1; out_ready = 1'b1; ks_done = 1'b1;
    n_ov = 0; done_cyc = -1;
    for (int c = 1; c <= 120; c++) begin
      tick();
      start = 1'b0;
      #1;
      if (out_valid) begin
        if (n_ov < 8) ov_cyc[n_ov] = c;
        n_ov++;
      end
      if (done) begin
        done_cyc = c;
        break;
      end
    end
    chk("tp_blocks", n_ov, 4);
    chk("tp_first_out", ov_cyc[0], 14);
    for (int k = 1; k < 4; k++) chk("tp_period", ov_cyc[k] - ov_cyc[k-1], PERIOD);
    chk("tp_done_cycle", done_cyc, 14 + 3 * PERIOD + 1);
    chk("tp_block_cnt", block_cnt, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: got no end of test, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/aes_round_ctrl.md
Name: aes_round_ctrl

Overview:
- Sequencer for the iterative AES round datapath inside the AES HWPE engine.
- Sits between the top-level aes_fsm (start, block count, key length) and the round datapath / key-schedule unit.
- Drives per-cycle load, round-enable, round-index and final-round controls; moves 128-bit blocks in and out via valid/ready handshakes.
- Counts blocks and pulses done at job end.

Parameters:
- CNT_W, 16, width of block counter and cfg_num_blocks
- RIDX_W, 4, width of round index (covers 0..14)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- clear  in  1  synchronous soft clear, same effect as reset
- start  in  1  job start pulse, sampled in IDLE only
- cfg_key_len  in  2  0=AES-128 (Nr=10), 1=AES-192 (Nr=12), 2=AES-256 (Nr=14), 3=illegal
- cfg_decrypt  in  1  1=inverse cipher
- cfg_num_blocks  in  CNT_W  blocks in job
- ks_start  out  1  one-cycle key-expansion trigger
- ks_done  in  1  key schedule ready, level or pulse
- in_valid  in  1  plaintext/ciphertext block available
- in_ready  out  1  block accepted when in_valid&in_ready
- dp_load  out  1  datapath loads input XOR round key dp_round_idx
- dp_round_en  out  1  datapath executes one round
- dp_round_idx  out  RIDX_W  round-key index for the current cycle
- dp_final_round  out  1  current round omits (Inv)MixColumns
- dp_inv  out  1  registered copy of cfg_decrypt
- out_valid  out  1  result block valid
- out_ready  in  1  sink accepts result
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at job end
- err_cfg  out  1  one-cycle pulse on illegal start
- block_cnt  out  CNT_W  blocks completed in current job

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high (reset). All state updates on the rising edge of clk.
- reset or clear:
  - state=IDLE; all outputs 0; block_cnt=0.
  - Overrides any in-flight block, no done pulse.
  - clear has priority over start in the same cycle.
- Nr and dir are latched at start; cfg_* changes mid-job are ignored.
- IDLE:
  - start with cfg_key_len==3: err_cfg=1 next cycle, stay IDLE.
  - start with cfg_num_blocks==0: done=1 next cycle, stay IDLE, no ks_start.
  - Otherwise on start: block_cnt=0 -> KEY_EXP, with ks_start=1 for exactly the first KEY_EXP cycle.
- KEY_EXP:
  - ks_done=1 -> READY.
  - ks_done sampled starting the cycle after ks_start.
- READY:
  - in_ready=1.
  - On in_valid: dp_load=1 in that cycle, dp_round_idx=0 (enc) or Nr (dec) -> ROUND.
- ROUND:
  - dp_round_en=1 every cycle.
  - dp_round_idx: enc 1,2..Nr; dec Nr-1..0.
  - dp_final_round=1 on the index Nr (enc) or 0 (dec) -> HOLD.
  - Exactly Nr ROUND cycles per block.
- HOLD:
  - out_valid=1, held stable until out_ready.
  - On handshake: block_cnt+1.
  - If the new count equals the latched num_blocks: done=1 next cycle (registered), -> IDLE.
  - Else -> READY.
- Latency: input handshake at cycle T -> out_valid at T+Nr+1 (11/13/15).
- in_ready=0 and dp_* =0 outside the conditions above; dp_round_idx=0 when idle.
- start while busy is ignored.
- block_cnt holds its final value in IDLE until the next accepted start.
- ks_done asserted in other states is ignored.

Optional Feature:
- Macro AES_ROUND_CTRL_BACK2BACK_EN.
- Defined:
  - In HOLD, when more blocks remain, in_ready=out_ready.
  - A simultaneous out and in handshake counts the block, asserts dp_load and goes directly to ROUND, skipping READY.
  - Throughput is 1 block per Nr+1 cycles.
- Undefined:
  - in_ready only in READY.
  - Throughput is 1 block per Nr+2 cycles minimum.
- Latency per block is unchanged in both cases.

Test Plan:
- AES-128 enc, num_blocks=1:
  - start, ks_done 3 cycles later, in_valid held high.
  - dp_load once with idx 0; dp_round_en 10 cycles with idx 1..10; final_round only at idx 10.
  - out_valid at T+11; out_ready -> block_cnt=1, done pulse, busy=0.
- AES-256 dec, num_blocks=2, out_ready held low 5 cycles:
  - idx sequence 14 (load), 13..0; final at 0.
  - out_valid stable 5 cycles.
  - Second block follows; done after block_cnt=2.
- cfg_key_len=3 start -> err_cfg single pulse, busy stays 0, no ks_start.
- cfg_num_blocks=0 start -> done pulse next cycle, no ks_start, no in_ready.
- AES-192 enc, 3 blocks, reset asserted during round 6 of block 2:
  - All outputs 0 next cycle, block_cnt=0, no done.
  - A new start works normally.
- With AES_ROUND_CTRL_BACK2BACK_EN, AES-128, 4 blocks, in_valid/out_ready always 1:
  - out_valid pulses every 11 cycles; done after 4th.
  - Without the macro: every 12 cycles.
